// File: rtl/service_4_timekeeper_pkg.sv
// Shared encodings and constants for the service_4 timekeeper.
// Mode/field codes, the time reset value and a BCD helper.
package service_4_timekeeper_pkg;

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;

    localparam logic FIELD_MIN  = 1'b0;
    localparam logic FIELD_HOUR = 1'b1;

    localparam logic [15:0] TIME_RST = 16'h0000;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/service_4_bcd_counter.sv
// Two-digit BCD up/down counter wrapping at MAX.
// carry_out flags an increment that wraps MAX -> 00.
module service_4_bcd_counter
    import service_4_timekeeper_pkg::*;
#(
    parameter int unsigned MAX     = 59,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       dec,
    input  logic       load_zero,
    output logic [7:0] value,
    output logic       carry_out
);

    localparam logic [7:0] MAX_BCD = to_bcd(MAX);

    logic [7:0] value_d;
    logic [7:0] value_q;

    always_comb begin
        value_d = value_q;
        if (load_zero) begin
            value_d = 8'h00;
        end else if (inc && !dec) begin
            if (value_q == MAX_BCD)
                value_d = 8'h00;
            else if (value_q[3:0] == 4'd9)
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            else
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
        end else if (dec && !inc) begin
            if (value_q == 8'h00)
                value_d = MAX_BCD;
            else if (value_q[3:0] == 4'd0)
                value_d = {value_q[7:4] - 4'd1, 4'd9};
            else
                value_d = {value_q[7:4], value_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) value_q <= RST_VAL;
        else         value_q <= value_d;
    end

    assign value     = value_q;
    assign carry_out = inc && !dec && !load_zero && (value_q == MAX_BCD);

endmodule

// File: rtl/service_4_timekeeper.sv
// 24-hour BCD clock with alarm register and switch/button set modes.
// Inputs are synchronized; buttons act once per press.
module service_4_timekeeper
    import service_4_timekeeper_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter logic [15:0] ALARM_RST = 16'h0700
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        SPDT_time,
    input  logic        SPDT_alarm,
    input  logic        push_u,
    input  logic        push_d,
    input  logic        push_l,
    input  logic        push_r,
    output logic [15:0] current,
    output logic [15:0] alarm,
    output logic [7:0]  seconds,
    output logic [1:0]  mode,
    output logic        field
);

    localparam int unsigned    PW        = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [5:0]    sync1_d, sync1_q, sync2_d, sync2_q;
    logic [3:0]    prev_d, prev_q, pulse;
    logic [1:0]    arm_d, arm_q;
    logic [1:0]    mode_d, mode_q;
    logic          field_d, field_q;
    logic [PW-1:0] presc_d, presc_q;
    logic          pu, pd, pl, pr, up, dn;
    logic          time_entry, set_entry, tick;
    logic          ed_time, ed_alarm;
    logic          sec_c, min_c, hr_c, amin_c, ahr_c;
    logic [7:0]    sec_v, min_v, hr_v, amin_v, ahr_v;
    logic          unused_carries;

    // Pulses stay masked until the synchronizer has settled after reset.
    assign pulse = sync2_q[3:0] & ~prev_q & {4{arm_q == 2'd3}};
    assign {pu, pd, pl, pr} = pulse;
    assign up = pu && !pd;
    assign dn = pd && !pu;

    always_comb begin
        sync1_d = {SPDT_time, SPDT_alarm, push_u, push_d, push_l, push_r};
        sync2_d = sync1_q;
        prev_d  = sync2_q[3:0];
        arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        if (sync2_q[5])      mode_d = MODE_SET_TIME;
        else if (sync2_q[4]) mode_d = MODE_SET_ALARM;
        else                 mode_d = MODE_RUN;
    end

    assign time_entry = (mode_d == MODE_SET_TIME) && (mode_q != MODE_SET_TIME);
    assign set_entry  = (mode_d != MODE_RUN) && (mode_d != mode_q);
    assign ed_time    = (mode_q == MODE_SET_TIME);
    assign ed_alarm   = (mode_q == MODE_SET_ALARM);
    assign tick       = !ed_time && !time_entry && (presc_q == PRESC_MAX);

    always_comb begin
        field_d = field_q;
        if (set_entry)                   field_d = FIELD_MIN;
        else if (mode_q != MODE_RUN && pl) field_d = FIELD_HOUR;
        else if (mode_q != MODE_RUN && pr) field_d = FIELD_MIN;
        presc_d = presc_q + PW'(1);
        if (ed_time || time_entry || presc_q == PRESC_MAX)
            presc_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
            mode_q  <= MODE_RUN;
            field_q <= FIELD_MIN;
            presc_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            mode_q  <= mode_d;
            field_q <= field_d;
            presc_q <= presc_d;
        end
    end

    service_4_bcd_counter #(.MAX(59), .RST_VAL(8'h00)) u_sec (
        .clk(clk), .resetn(resetn),
        .inc(tick), .dec(1'b0), .load_zero(time_entry),
        .value(sec_v), .carry_out(sec_c)
    );

    service_4_bcd_counter #(.MAX(59), .RST_VAL(TIME_RST[7:0])) u_min (
        .clk(clk), .resetn(resetn),
        .inc(sec_c || (ed_time && up && field_q == FIELD_MIN)),
        .dec(ed_time && dn && field_q == FIELD_MIN),
        .load_zero(1'b0),
        .value(min_v), .carry_out(min_c)
    );

    // Hour carry only follows a tick-driven minute wrap, never an edit.
    service_4_bcd_counter #(.MAX(23), .RST_VAL(TIME_RST[15:8])) u_hr (
        .clk(clk), .resetn(resetn),
        .inc((min_c && sec_c) || (ed_time && up && field_q == FIELD_HOUR)),
        .dec(ed_time && dn && field_q == FIELD_HOUR),
        .load_zero(1'b0),
        .value(hr_v), .carry_out(hr_c)
    );

    service_4_bcd_counter #(.MAX(59), .RST_VAL(ALARM_RST[7:0])) u_amin (
        .clk(clk), .resetn(resetn),
        .inc(ed_alarm && up && field_q == FIELD_MIN),
        .dec(ed_alarm && dn && field_q == FIELD_MIN),
        .load_zero(1'b0),
        .value(amin_v), .carry_out(amin_c)
    );

    service_4_bcd_counter #(.MAX(23), .RST_VAL(ALARM_RST[15:8])) u_ahr (
        .clk(clk), .resetn(resetn),
        .inc(ed_alarm && up && field_q == FIELD_HOUR),
        .dec(ed_alarm && dn && field_q == FIELD_HOUR),
        .load_zero(1'b0),
        .value(ahr_v), .carry_out(ahr_c)
    );

    assign unused_carries = &{1'b0, hr_c, amin_c, ahr_c};

    assign current = {hr_v, min_v};
    assign alarm   = {ahr_v, amin_v};
    assign seconds = sec_v;
    assign mode    = mode_q;
    assign field   = field_q;

endmodule

// File: tb/tb_service_4_timekeeper.sv
// Directed bench for service_4_timekeeper at CLK_HZ=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_service_4_timekeeper;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sw_time = 1'b0;
    logic        sw_alarm = 1'b0;
    logic [3:0]  btn = 4'b0000;
    logic [15:0] current, alarm;
    logic [7:0]  seconds;
    logic [1:0]  mode;
    logic        field;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    service_4_timekeeper #(.CLK_HZ(4), .ALARM_RST(16'h0700)) dut (
        .clk(clk), .resetn(resetn),
        .SPDT_time(sw_time), .SPDT_alarm(sw_alarm),
        .push_u(btn[3]), .push_d(btn[2]),
        .push_l(btn[1]), .push_r(btn[0]),
        .current(current), .alarm(alarm), .seconds(seconds),
        .mode(mode), .field(field)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            btn = b;
            repeat (4) @(negedge clk);
            btn = 4'b0000;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_sec_change(output int n);
        logic [7:0] s0;
        s0 = seconds;
        n = 0;
        while (seconds == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [7:0] s0;

        #12;
        chk("rst_cur", current, 16'h0000);
        chk("rst_sec", seconds, 8'h00);
        chk("rst_alm", alarm, 16'h0700);
        chk("rst_mode", mode, 2'b00);
        chk("rst_field", field, 1'b0);

        @(negedge clk);
        resetn = 1'b1;
        repeat (239) @(negedge clk);
        chk("t59_sec", seconds, 8'h59);
        chk("t59_cur", current, 16'h0000);
        @(negedge clk);
        chk("t60_cur", current, 16'h0001);
        chk("t60_sec", seconds, 8'h00);

        sw_time = 1'b1;
        repeat (5) @(negedge clk);
        chk("st_mode", mode, 2'b01);
        chk("st_sec0", seconds, 8'h00);
        chk("st_field", field, 1'b0);
        press(4'b0100, 2);
        chk("st_min_wrap", current, 16'h0059);
        press(4'b0010, 1);
        chk("st_field_h", field, 1'b1);
        press(4'b0100, 1);
        chk("st_hr_wrap", current, 16'h2359);
        repeat (12) @(negedge clk);
        chk("st_frozen", {current, seconds}, {16'h2359, 8'h00});

        sw_time = 1'b0;
        n = 0;
        while (seconds != 8'h58 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("sec58", seconds, 8'h58);
        wait_sec_change(n);
        chk("sec59", seconds, 8'h59);
        chk("cur2359", current, 16'h2359);
        wait_sec_change(n);
        chk("tick_gap", n, 4);
        chk("wrap_cur", current, 16'h0000);
        chk("wrap_sec", seconds, 8'h00);

        sw_alarm = 1'b1;
        repeat (5) @(negedge clk);
        chk("sa_mode", mode, 2'b10);
        chk("sa_field", field, 1'b0);
        s0 = seconds;
        press(4'b0010, 1);
        press(4'b0100, 4);
        chk("alm_h_dn4", alarm, 16'h0300);
        press(4'b0001, 1);
        chk("sa_field_m", field, 1'b0);
        press(4'b0100, 1);
        chk("alm_m_dn", alarm, 16'h0359);
        press(4'b1000, 1);
        chk("alm_m_wrap", alarm, 16'h0300);
        chk("alm_tick_runs", seconds != s0, 1'b1);

        sw_alarm = 1'b0;
        sw_time  = 1'b1;
        repeat (5) @(negedge clk);
        chk("st2_mode", mode, 2'b01);
        chk("st2_field", field, 1'b0);
        press(4'b0010, 1);
        press(4'b1000, 12);
        press(4'b0001, 1);
        press(4'b1000, 30);
        chk("set1230", current, 16'h1230);
        btn = 4'b1000;
        repeat (50) @(negedge clk);
        btn = 4'b0000;
        repeat (4) @(negedge clk);
        chk("hold_once", current, 16'h1231);
        press(4'b1100, 1);
        chk("ud_ignored", current, 16'h1231);
        chk("alm_kept", alarm, 16'h0300);

        sw_alarm = 1'b1;
        repeat (5) @(negedge clk);
        chk("both_mode", mode, 2'b01);
        btn = 4'b1000;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_cur", current, 16'h0000);
        chk("mid_alm", alarm, 16'h0700);
        chk("mid_mode", mode, 2'b00);
        chk("mid_sec", seconds, 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        chk("held_mode", mode, 2'b01);
        chk("held_cur", current, 16'h0000);
        btn = 4'b0000;
        sw_time  = 1'b0;
        sw_alarm = 1'b0;
        repeat (5) @(negedge clk);
        chk("run_mode", mode, 2'b00);
        press(4'b1000, 1);
        press(4'b0100, 1);
        chk("run_no_edit", current, 16'h0000);
        chk("run_alm", alarm, 16'h0700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/service_4_timekeeper.md
SERVICE_4_TIMEKEEPER -- requirements
Module: service_4_timekeeper

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning the clk cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have parameter ALARM_RST, default 16'h0700, meaning the BCD HHMM alarm value loaded at reset.
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port SPDT_time, input, 1, meaning the switch that requests time-set mode (asynchronous level).
REQ-006 The block SHALL have port SPDT_alarm, input, 1, meaning the switch that requests alarm-set mode (asynchronous level).
REQ-007 The block SHALL have port push_u, input, 1, meaning the increment button (asynchronous, active-high).
REQ-008 The block SHALL have port push_d, input, 1, meaning the decrement button (asynchronous, active-high).
REQ-009 The block SHALL have port push_l, input, 1, meaning the field-select-hour button (asynchronous, active-high).
REQ-010 The block SHALL have port push_r, input, 1, meaning the field-select-minute button (asynchronous, active-high).
REQ-011 The block SHALL have port current, output, 16, meaning the BCD {Htens,Hones,Mtens,Mones} of the running time, 00:00..23:59.
REQ-012 The block SHALL have port alarm, output, 16, meaning the BCD HHMM alarm time.
REQ-013 The block SHALL have port seconds, output, 8, meaning the BCD seconds, 00..59.
REQ-014 The block SHALL have port mode, output, 2, meaning 00 = RUN, 01 = SET_TIME, 10 = SET_ALARM.
REQ-015 The block SHALL have port field, output, 1, meaning 0 = minute field selected and 1 = hour field selected.

Function
REQ-016 All switch and button inputs SHALL pass through a 2-flop synchronizer.
REQ-017 Each button SHALL produce a one-cycle pulse on its synchronized rising edge: one press gives exactly one action, and holding the button gives no repeat.
REQ-018 The mode FSM SHALL have states RUN, SET_TIME and SET_ALARM, and SHALL be re-evaluated every cycle from the synchronized switches: SPDT_time=1 gives SET_TIME (priority), else SPDT_alarm=1 gives SET_ALARM, else RUN.
REQ-019 On entry to SET_TIME, seconds SHALL clear to 00 and the prescaler SHALL clear to 0.
REQ-020 While in SET_TIME, time SHALL be frozen except for edits.
REQ-021 On entry to either set state, field SHALL be set to 0 (minute).
REQ-022 A push_l pulse SHALL set field=1 and a push_r pulse SHALL set field=0; these are ignored in RUN.
REQ-023 In RUN, the prescaler SHALL count 0..CLK_HZ-1 and the tick SHALL assert on the cycle the count equals CLK_HZ-1.
REQ-024 On each tick, seconds SHALL increment, and 59->00 SHALL carry to minutes.
REQ-025 Minutes 59->00 SHALL carry to hours, and hours 23->00 SHALL wrap, so 23:59:59 becomes 00:00:00 in one tick.
REQ-026 current and seconds SHALL update together on the tick edge, with no intermediate values visible.
REQ-027 In SET_ALARM, time SHALL keep running exactly as in RUN.
REQ-028 In a set state, a push_u pulse SHALL increment the selected field of the target: current in SET_TIME, alarm in SET_ALARM.
REQ-029 In a set state, a push_d pulse SHALL decrement the selected field of the same target.
REQ-030 Edits SHALL wrap within the field with no carry: minutes 59<->00 and hours 23<->00.
REQ-031 A simultaneous push_u and push_d pulse SHALL be ignored.
REQ-032 In RUN, push_u and push_d SHALL have no effect.
REQ-033 Every digit SHALL always be valid BCD; no state SHALL produce A-F.
REQ-034 alarm SHALL change only by edits in SET_ALARM.

Reset
REQ-035 Asserting resetn low SHALL immediately set current=16'h0000, seconds=8'h00, alarm=ALARM_RST, mode=00, field=0, and clear the prescaler, synchronizers and edge detectors.
REQ-036 Reset assertion mid-operation, including mid-edit or on a tick cycle, SHALL override everything.
REQ-037 After resetn deasserts, no spurious button pulse SHALL be generated if a button is held.

Structure
REQ-038 A shared package SHALL hold the mode encodings, the field encoding, and the 16'h0000 reset constant.
REQ-039 One sub-module SHALL be used: service_4_bcd_counter, a two-digit BCD counter with parameter MAX (59 or 23) and ports inc, dec, load_zero, value and carry_out. It is instantiated for seconds, minutes, hours, alarm minutes and alarm hours.

Verification
REQ-040 A bench with CLK_HZ=4 running from reset in RUN for 240 cycles SHALL see current=16'h0001 and seconds=8'h00 exactly at the 60th tick.
REQ-041 Forcing 23:59:58 via SET_TIME edits and then running 2 ticks SHALL show seconds 59, then current=16'h0000 and seconds=8'h00.
REQ-042 With SET_ALARM active, field=1, and alarm=16'h0700, four push_d pulses SHALL give alarm=16'h0300; with field=0, one push_d SHALL give alarm=16'h0359 with the hour unchanged.
REQ-043 Holding push_u high for 50 cycles in SET_TIME with current 12:30 and field=0 SHALL give exactly 12:31; a simultaneous push_u and push_d pulse SHALL leave it unchanged.
REQ-044 With both switches high, mode SHALL be 01; asserting resetn low mid-edit SHALL immediately give current=0000, alarm=0700 and mode=00.
REQ-045 In SET_ALARM, the tick SHALL continue, so seconds advances while alarm edits apply.
